// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption core: one cipher round per clock, key schedule expanded on the fly.
// Byte 0 of every 128-bit block sits in bits [127:120]; the state is column-major (row k%4, col k/4).
module aes128_encrypt_core #(
  parameter int unsigned NR = 10
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  localparam logic [3:0] LastRound = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse computed as a^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic [127:0] out_q, out_d;
  logic         valid_q, valid_d;

  logic [127:0] sr_w;
  logic [127:0] mc_w;
  logic [127:0] rk_next;
  logic [127:0] round_out;

  // Round datapath: SubBytes, ShiftRows, MixColumns and the next round key.
  always_comb begin
    logic [7:0]  sb [16];
    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] t, w0, w1, w2, w3;
    sr_w = '0;
    mc_w = '0;
    for (int k = 0; k < 16; k++) sb[k] = sbox(state_q[127-8*k -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr_w[127-8*(r+4*c) -: 8] = sb[r + 4*((c + r) % 4)];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr_w[127-32*c -: 8];
      a1 = sr_w[119-32*c -: 8];
      a2 = sr_w[111-32*c -: 8];
      a3 = sr_w[103-32*c -: 8];
      mc_w[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc_w[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc_w[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc_w[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    t  = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon(round_q), 24'h0};
    w0 = key_q[127:96] ^ t;
    w1 = key_q[95:64] ^ w0;
    w2 = key_q[63:32] ^ w1;
    w3 = key_q[31:0] ^ w2;
    rk_next   = {w0, w1, w2, w3};
    round_out = ((round_q == LastRound) ? sr_w : mc_w) ^ rk_next;
  end

  // Control: capture when idle, iterate rounds while busy, publish on the last round.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    busy_d  = busy_q;
    out_d   = out_q;
    valid_d = 1'b0;
    if (!busy_q) begin
      if (AES_en) begin
        state_d = AES_data_in ^ AES_key_in;
        key_d   = AES_key_in;
        round_d = 4'd1;
        busy_d  = 1'b1;
      end
    end else begin
      state_d = round_out;
      key_d   = rk_next;
      if (round_q == LastRound) begin
        out_d   = round_out;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        round_d = 4'd0;
      end else begin
        round_d = round_q + 4'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign AES_data_out       = out_q;
  assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core against a byte-array AES-128 reference model.
module tb_aes128_encrypt_core;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] out;
  logic         valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sbox_t [256];

  aes128_encrypt_core #(.NR(10)) dut (
    .AES_clk            (clk),
    .AES_rst_n          (rst_n),
    .AES_en             (en),
    .AES_data_in        (data_in),
    .AES_key_in         (key_in),
    .AES_data_out       (out),
    .AES_data_out_valid (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Polynomial product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r + 4*((c + r) % 4)];
      for (int k = 0; k < 16; k++) s[k] = t[k];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gmul(s[4*c], 2) ^ gmul(s[4*c+1], 3) ^ s[4*c+2] ^ s[4*c+3];
          t[4*c+1] = s[4*c] ^ gmul(s[4*c+1], 2) ^ gmul(s[4*c+2], 3) ^ s[4*c+3];
          t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2], 2) ^ gmul(s[4*c+3], 3);
          t[4*c+3] = gmul(s[4*c], 3) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3], 2);
        end
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
    @(negedge clk);
    data_in = pt;
    key_in  = key;
    en      = 1'b1;
  endtask

  // Inputs are already set up for the coming capture edge; scrambles them once captured.
  task automatic finish_block(input string tag, input logic [127:0] exp, input bit chk_r1,
                              input logic [127:0] r1);
    int lat;
    @(posedge clk);
    @(negedge clk);
    en      = 1'b0;
    data_in = rnd128();
    key_in  = rnd128();
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (chk_r1 && lat == 1) check_eq({tag, "_round1"}, dut.state_q, r1);
    end while (!valid && lat < 20);
    check_eq({tag, "_latency"}, 128'(lat), 128'd10);
    check_eq({tag, "_out"}, out, exp);
    @(posedge clk);
    #1;
    check_eq({tag, "_valid_falls"}, 128'(valid), 128'd0);
    check_eq({tag, "_out_holds"}, out, exp);
  endtask

  initial begin
    logic [127:0] cap_pt;
    logic [127:0] cap_key;
    int seen;
    build_sbox();
    rst_n   = 1'b0;
    en      = 1'b1;
    data_in = 128'h00112233445566778899aabbccddeeff;
    key_in  = 128'h000102030405060708090a0b0c0d0e0f;

    // Reset held with en high: outputs stay zero and nothing is captured.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_out", out, '0);
      check_eq("rst_valid", 128'(valid), 128'd0);
    end
    rst_n = 1'b1;
    finish_block("fips_c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, '0);

    start_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    finish_block("fips_b", 128'h3925841d02dc09fbdc118597196a0b32, 1'b1,
                 128'ha49c7ff2689f352b6b5bea43026a5049);

    start_block('0, '0);
    finish_block("zero", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0, '0);

    for (int i = 0; i < 6; i++) begin
      cap_pt  = rnd128();
      cap_key = rnd128();
      start_block(cap_pt, cap_key);
      finish_block("random", ref_encrypt(cap_pt, cap_key), 1'b0, '0);
    end

    // en held high with inputs changing every cycle: captures every 11 clocks.
    @(negedge clk);
    en      = 1'b1;
    data_in = rnd128();
    key_in  = rnd128();
    cap_pt  = '0;
    cap_key = '0;
    for (int j = 0; j < 55; j++) begin
      if (j % 11 == 0) begin
        cap_pt  = data_in;
        cap_key = key_in;
      end
      @(posedge clk);
      #1;
      check_eq("cont_valid", 128'(valid), 128'((j % 11) == 10));
      if (j % 11 == 10) check_eq("cont_out", out, ref_encrypt(cap_pt, cap_key));
      @(negedge clk);
      data_in = rnd128();
      key_in  = rnd128();
    end
    en = 1'b0;

    // Reset in the middle of an encryption aborts it with no valid pulse.
    repeat (2) @(posedge clk);
    start_block(rnd128(), rnd128());
    @(posedge clk);
    en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out", out, '0);
    check_eq("abort_valid", 128'(valid), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (valid) seen++;
    end
    check_eq("abort_no_pulse", 128'(seen), 128'd0);
    check_eq("abort_out_after", out, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_core.md
Name: aes128_encrypt_core

Overview:
Iterative AES-128 encryption engine (FIPS-197) that turns one 128-bit plaintext block and a 128-bit cipher key into a 128-bit ciphertext. It executes one cipher round per clock and expands the key schedule on the fly. It is the top-level crypto datapath and is driven by a simple level-enable / valid-pulse interface. Decryption is not supported.

Parameters:
NR, 10, number of cipher rounds. Fixed for AES-128; the only legal value is 10.

Ports:
AES_clk  input  1  system clock; all state updates on the rising edge
AES_rst_n  input  1  reset, asynchronous assert, active-low
AES_en  input  1  start request (level); sampled only while the core is idle
AES_data_in  input  128  plaintext block; bits [127:120] = byte 0 (FIPS input byte in0)
AES_key_in  input  128  cipher key; bits [127:120] = key byte 0
AES_data_out  output  128  ciphertext; same byte ordering as the inputs; holds until the next completion
AES_data_out_valid  output  1  one-cycle pulse marking a new AES_data_out

Behaviour:
- Reset: the core is asynchronous and active-low. While AES_rst_n=0:
  - AES_data_out=0, AES_data_out_valid=0.
  - busy=0, round counter=0, state and round-key registers=0.
- State layout follows FIPS-197: byte k sits at row k%4, column k/4 (column-major). Byte 0 occupies bits [127:120].
- Idle: busy=0. AES_en is sampled on each rising edge.
- Capture edge E0 (AES_en=1 and busy=0):
  - state <= AES_data_in XOR AES_key_in (initial AddRoundKey).
  - round key <= AES_key_in.
  - round counter <= 1, busy <= 1.
  - AES_data_in and AES_key_in are ignored from then until the core is idle again.
- Round edges E1..E10 (busy=1, counter r = 1..10):
  - Next round key is computed combinationally from the current one. Take the last word, apply RotWord, then SubWord, then XOR Rcon[r] into byte 0. Rcon = 01,02,04,08,10,20,40,80,1b,36. Then apply the XOR chain w0..w3.
  - Rounds 1..9: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state)))).
  - Round 10: same, but with no MixColumns.
  - The new round key is registered on the same edge as the state.
- Completion at E10:
  - AES_data_out <= round-10 result.
  - AES_data_out_valid <= 1 for exactly one cycle (high from E10 to E11).
  - busy <= 0, counter <= 0.
- Latency and throughput:
  - Valid rises 10 clocks after the capture edge.
  - The earliest next capture is E11, so back-to-back throughput is one block per 11 clocks.
- AES_en held high continuously: the core re-captures at every idle edge and produces a pulse every 11 cycles. Inputs are re-sampled at each capture.
- AES_en deasserted mid-operation: no effect. The encryption in progress completes and its valid pulse is produced.
- AES_en=1 during the valid cycle: the new capture occurs at E11, and the valid pulse is not extended.
- Reset asserted mid-operation: the operation is aborted immediately, outputs go to 0, and no valid pulse follows.
- S-box: a forward S-box only, used by SubBytes (16 instances) and SubWord (4 instances). It may be a shared combinational function, either a lookup or a GF(2^8) composite-field inverse plus affine transform. It must be bit-exact to FIPS-197.
- MixColumns uses the xtime arithmetic in GF(2^8), polynomial 0x11b.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold AES_rst_n=0 with AES_en=1 for 3 cycles -> AES_data_out=0, valid=0, no capture. Release reset -> capture occurs on the first edge that has AES_en=1.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, AES_en pulsed for one cycle -> valid pulses exactly 10 clocks after capture, out = 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out = 3925841d02dc09fbdc118597196a0b32. Also check the round-1 state after E1 = a49c7ff2689f352b6b5bea43026a5049.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e. AES_data_out holds that value after valid falls.
- Continuous AES_en=1 for 50 cycles while AES_data_in changes mid-run -> valid pulses every 11 cycles. Each result matches the inputs present at its own capture edge, and input changes during busy have no effect.
- Reset asserted at round 5, then released with AES_en=0 -> out=0, and no valid pulse ever appears.
